i2c_mem_slave: RTL

I2C_MEM_SLAVE -- requirements
Module: i2c_mem_slave

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_sync_edge.sv | 35 +++
 rtl/i2c_mem_slave.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte/address widths and the slave FSM state type.
`timescale 1ns/1ps
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        WRITE,
        ACK_DATA,
        READ,
        MASTER_ACK,
        WAIT_STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one I2C line into clk and produces level plus rise/fall pulses.
`timescale 1ns/1ps
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Reset to 1 so an idle bus produces no spurious edges when reset drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C slave fronting a byte memory: the 7-bit bus address selects the location,
// one byte is written or read per transaction, every address is acknowledged.
`timescale 1ns/1ps
module i2c_mem_slave
    import i2c_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 128,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  logic              sda,
    output logic              busy,
    output logic              done,
    output logic [BYTE_W-1:0] rx_data,
    output logic              ackErr
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    i2c_state_t        state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0] shift, shift_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              rw, rw_n;
    logic              sda_oe, sda_oe_n;
    logic              busy_n, done_n, ack_err_n;
    logic [BYTE_W-1:0] rx_data_n;
    logic              mem_we;
    logic [BYTE_W-1:0] rd_byte, wr_byte;
    logic [BYTE_W-1:0] mem [MEM_DEPTH];

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk(clk), .rst(rst), .d(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk(clk), .rst(rst), .d(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start   = sda_fall & scl_lvl;
    assign stop    = sda_rise & scl_lvl;
    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign rd_byte = mem[addr];
    assign wr_byte = {shift[BYTE_W-2:0], sda_lvl};

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        addr_n    = addr;
        rw_n      = rw;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        ack_err_n = ackErr;
        rx_data_n = rx_data;
        done_n    = 1'b0;
        mem_we    = 1'b0;

        if (start) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b1;
            ack_err_n = 1'b0;
        end else if (stop) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            done_n    = (state == WAIT_STOP);
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = wr_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_n   = ACK_ADDR;
                        bit_cnt_n = '0;
                        sda_oe_n  = 1'b1;
                        addr_n    = shift[BYTE_W-1:1];
                        rw_n      = shift[0];
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (rw) begin
                            state_n  = READ;
                            shift_n  = rd_byte;
                            sda_oe_n = ~rd_byte[BYTE_W-1];
                        end else begin
                            state_n  = WRITE;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = wr_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            mem_we    = 1'b1;
                            rx_data_n = wr_byte;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_n   = ACK_DATA;
                        bit_cnt_n = '0;
                        sda_oe_n  = 1'b1;
                    end
                end
                ACK_DATA: begin
                    if (scl_fall) begin
                        state_n  = WAIT_STOP;
                        sda_oe_n = 1'b0;
                    end
                end
                // bit_cnt counts bits already shifted out after bit 7 went on entry
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt < 4'd7) begin
                            shift_n   = {shift[BYTE_W-2:0], 1'b0};
                            sda_oe_n  = ~shift[BYTE_W-2];
                            bit_cnt_n = bit_cnt + 4'd1;
                        end else begin
                            state_n   = MASTER_ACK;
                            bit_cnt_n = '0;
                            sda_oe_n  = 1'b0;
                        end
                    end
                end
                MASTER_ACK: begin
                    if (scl_rise) begin
                        ack_err_n = ackErr | sda_lvl;
                        state_n   = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            addr    <= '0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ackErr  <= 1'b0;
            rx_data <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            addr    <= addr_n;
            rw      <= rw_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            done    <= done_n;
            ackErr  <= ack_err_n;
            rx_data <= rx_data_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr] <= wr_byte;
        end
    end

endmodule
